// File: rtl/cache_pkg.sv
// Shared types for the 4-way cache miss sequencer: FSM states, way index
// and way-mask types, and the free-way priority helper.
package cache_pkg;

  localparam int unsigned NWAYS = 4;

  typedef logic [1:0]       way_t;
  typedef logic [NWAYS-1:0] way_mask_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WRBACK = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Scans high to low so the lowest-numbered invalid way is the one kept.
  function automatic way_t lowest_free(input way_mask_t valid);
    way_t w;
    w = '0;
    for (int unsigned i = NWAYS; i > 0; i--) begin
      if (!valid[i-1]) w = way_t'(i - 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Fill-way selection: lowest free way if any, else the round-robin pointer,
// which advances only when a full set forces an eviction.
module cache_victim_select
  import cache_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  way_mask_t way_valid_i,
  input  logic      miss_i,
  output way_t      sel_way_o,
  output logic      all_full_o,
  output logic      evict_o
);

  way_t rr_ptr_q, rr_ptr_d;

  always_comb begin
    all_full_o = &way_valid_i;
    sel_way_o  = all_full_o ? rr_ptr_q : lowest_free(way_valid_i);
    evict_o    = miss_i & all_full_o;
    rr_ptr_d   = evict_o ? rr_ptr_q + way_t'(1) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/cache_miss_controller.sv
// Miss sequencer for the 4-way set-associative cache: hit/miss resolution,
// victim write-back, line fill and array update for one CPU access at a time.
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [IDX_W-1:0]  arr_idx,
  input  logic [3:0]        way_valid,
  input  logic [3:0]        way_dirty,
  input  logic              hit,
  input  logic [1:0]        hit_way,
  output logic [1:0]        arr_rd_way,
  input  logic [ADDR_W-IDX_W-1:0] arr_rd_tag,
  input  logic [DATA_W-1:0] arr_rd_data,
  output logic              arr_we,
  output logic [1:0]        arr_way,
  output logic              arr_valid,
  output logic              arr_dirty,
  output logic [DATA_W-1:0] arr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              evict,
  output logic              busy
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  way_t                way_q, way_d;
  logic [DATA_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                gap_q, gap_d;

  way_t                sel_way;
  logic                all_full;
  logic                vs_evict;
  logic                lookup_miss;

  assign lookup_miss = (state_q == LOOKUP) && !hit;

  cache_victim_select u_victim (
    .clk         (clk),
    .rst         (rst),
    .way_valid_i (way_valid),
    .miss_i      (lookup_miss),
    .sel_way_o   (sel_way),
    .all_full_o  (all_full),
    .evict_o     (vs_evict)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      way_q     <= '0;
      line_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      way_q     <= way_d;
      line_q    <= line_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    way_d     = way_q;
    line_d    = line_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    gap_d     = gap_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          way_d = hit_way;
          if (we_q) begin
            state_d = UPDATE;
          end else begin
            line_d  = arr_rd_data;
            state_d = RESP;
          end
        end else begin
          // Victim tag/data are captured here so write-back stays stable.
          way_d     = sel_way;
          wb_addr_d = {arr_rd_tag, addr_q[IDX_W-1:0]};
          wb_data_d = arr_rd_data;
          state_d   = (way_valid[sel_way] && way_dirty[sel_way]) ? WRBACK : FILL;
        end
      end
      WRBACK: begin
        if (mem_ack) begin
          gap_d   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        // After a write-back, the first FILL cycle keeps mem_req low.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = UPDATE;
        end
      end
      UPDATE:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    cpu_ready  = (state_q == RESP);
    cpu_rdata  = ((state_q == RESP) && !we_q) ? line_q : '0;
    arr_idx    = addr_q[IDX_W-1:0];
    arr_rd_way = way_q;
    arr_we     = 1'b0;
    arr_way    = way_q;
    arr_valid  = 1'b0;
    arr_dirty  = 1'b0;
    arr_data   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    evict      = vs_evict;
    unique case (state_q)
      LOOKUP: arr_rd_way = hit ? hit_way : sel_way;
      WRBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_addr_q;
        mem_wdata = wb_data_q;
      end
      FILL: begin
        mem_req  = !gap_q;
        mem_addr = addr_q;
      end
      UPDATE: begin
        arr_we    = 1'b1;
        arr_valid = 1'b1;
        arr_dirty = we_q;
        arr_data  = we_q ? wdata_q : line_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_miss_controller.md
# cache_miss_controller

Sequencer for the 4-way set-associative cache: accepts one CPU access at a time, resolves hit/miss against the tag array, and on a miss picks the line to fill. A free (invalid) way is preferred; otherwise a round-robin victim is evicted, with write-back if the victim is dirty. It then fetches the line from memory and updates the array. The block sits between the CPU port, the tag/data arrays and the memory bus, and owns all array write enables and the memory handshake.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 32, data word width (one word per line)
- IDX_W, 4, set index width; TAG_W = ADDR_W-IDX_W (derived localparam)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req / cpu_we  in  1 / 1  access request / write when 1
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  access address / write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- arr_idx  out  IDX_W  set index presented to arrays (latched addr)
- way_valid / way_dirty  in  4 / 4  valid / dirty bits of addressed set
- hit / hit_way  in  1 / 2  tag-compare result for latched address
- arr_rd_way  out  2  way whose tag/data the arrays return combinationally
- arr_rd_tag / arr_rd_data  in  TAG_W / DATA_W  tag/data of arr_rd_way
- arr_we  out  1  array write strobe
- arr_way / arr_valid / arr_dirty  out  2 / 1 / 1  write target way, valid bit, dirty bit
- arr_data  out  DATA_W  write data
- mem_req / mem_we  out  1 / 1  memory request / write-back when 1
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write-back data
- mem_ack  in  1  memory accepts (write) or returns data (read)
- mem_rdata  in  DATA_W  fill data, valid with mem_ack
- evict  out  1  one-cycle pulse when a valid line is displaced
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOOKUP, WRBACK, FILL, UPDATE, RESP.
- IDLE: on cpu_req=1 latch addr/we/wdata → LOOKUP. cpu_req ignored in all other states.
- LOOKUP: read hit → RESP, cpu_rdata = arr_rd_data with arr_rd_way=hit_way. Write hit → UPDATE on hit_way. Miss: select way, latch it. Victim valid&dirty → WRBACK; else → FILL. evict pulses here if selected way valid.
- Way selection: any way with way_valid=0 → lowest such index. All valid → rr_ptr; rr_ptr increments (3 wraps to 0) only on an all-valid miss.
- WRBACK: mem_req=1, mem_we=1, mem_addr={arr_rd_tag, idx}, mem_wdata=arr_rd_data (captured on LOOKUP exit, held stable). On mem_ack → FILL.
- FILL: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack capture mem_rdata → UPDATE.
- UPDATE: arr_we=1 for one cycle. arr_valid=1, arr_dirty=latched we. arr_data=cpu_wdata on write, else fill data → RESP.
- RESP: cpu_ready=1 one cycle; cpu_rdata = line data (read) or 0 (write) → IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, latched registers 0.
- Read hit: req sampled cycle 0, cpu_ready cycle 2. Write hit: cycle 3.
- Clean miss: mem_req rises cycle 2; ack at cycle k → UPDATE k+1, cpu_ready k+2.
- Dirty miss: write-back precedes fill. mem_req drops for exactly one cycle between the two transactions.
- mem_req, mem_addr, mem_we, mem_wdata stable from assertion until mem_ack sampled; mem_ack with mem_req=0 ignored.
- Earliest next accept: IDLE cycle after RESP.
- rst mid-operation: next cycle is IDLE, mem_req=0, arr_we=0; no partial array write. Memory transaction is abandoned.

## Structure
- cache_pkg: state enum, NWAYS=4, way_t (logic [1:0]), way-mask type.
- Sub-module cache_victim_select: free-way priority encoder, rr_ptr register and evict/all-full flag. Combinational select, registered pointer.

## Test plan
- Read hit, way 2 valid, arr_rd_data=0xCAFE0001 → cpu_ready cycle 2, cpu_rdata=0xCAFE0001, mem_req never asserted.
- Write miss, way_valid=4'b1011 → way 2 chosen, FILL only, UPDATE arr_way=2, arr_dirty=1, arr_data=cpu_wdata, evict=0.
- Four read misses to one set with all ways valid and clean → victims 0,1,2,3; fifth miss → way 0; evict pulses each time.
- Dirty victim, tag 0x0A5, idx 3, mem_ack delayed 5 cycles → mem_we=1 write-back to addr 0x0A53, address stable until ack. Then read fill; cpu_ready 2 cycles after fill ack.
- rst during FILL with mem_ack pending → mem_req=0 next cycle, busy=0, no arr_we. Next request serviced normally with rr_ptr=0.
- cpu_req toggled while busy → ignored; exactly one cpu_ready per accepted request.
